// File: rtl/umem_arbiter_pkg.sv
// Shared constants for the unified-memory arbiter: state encodings, grant ids, default widths.
// The optional watchdog is enabled by defining UMEM_ARB_TIMEOUT_EN.
package umem_arbiter_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int ADDR_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 255;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE    = 2'd0;
    localparam arb_state_t GRANT_F = 2'd1;
    localparam arb_state_t GRANT_D = 2'd2;

    localparam logic FETCH = 1'b0;
    localparam logic DATA  = 1'b1;

endpackage

// File: rtl/umem_arbiter_if.sv
// Memory-side req/ack port of the arbiter; master = arbiter, slave = memory.
interface umem_arbiter_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/umem_arb_watchdog.sv
// Grant watchdog: counts cycles while enabled, expires in the TIMEOUT-th cycle of a grant.
// Only instantiated when UMEM_ARB_TIMEOUT_EN is defined.
module umem_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rstn,
    input  logic load,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + 1'b1;
        end
    end

    assign expire = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/umem_arbiter.sv
// Arbitrates the CPU fetch and load/store paths onto one req/ack memory port.
// Define UMEM_ARB_TIMEOUT_EN to add the grant watchdog and sticky arb_err.
module umem_arbiter
    import umem_arbiter_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [XLEN-1:0]   if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    output logic [XLEN-1:0]   d_rdata,
    output logic              d_valid,
    output logic              cpu_stall,
    umem_arbiter_if.master    mem,
    output logic              arb_err
);

    arb_state_t      state;
    logic            last_grant;
    logic            f_pend;
    logic            d_pend;
    logic            grant_d;
    logic            grant_f;
    logic            timed_out;
    logic            done;
    logic [XLEN-1:0] resp_data;

    // A request whose valid is pulsing right now has already been served.
    assign f_pend    = if_req & ~if_valid;
    assign d_pend    = d_req & ~d_valid;
    assign cpu_stall = f_pend | d_pend;

    assign grant_d = d_pend & ~((last_grant == DATA) & f_pend);
    assign grant_f = f_pend & ~grant_d;

`ifdef UMEM_ARB_TIMEOUT_EN
    umem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rstn   (rstn),
        .load   (state == IDLE),
        .enable (state != IDLE),
        .expire (timed_out)
    );

    assign resp_data = mem.mem_ack ? mem.mem_rdata : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            arb_err <= 1'b0;
        end else if ((state != IDLE) && timed_out && !mem.mem_ack) begin
            arb_err <= 1'b1;
        end
    end
`else
    logic [31:0] timeout_unused;

    assign timeout_unused = 32'(TIMEOUT);
    assign timed_out      = 1'b0;
    assign resp_data      = mem.mem_rdata;
    assign arb_err        = 1'b0;
`endif

    assign done = (state != IDLE) & (mem.mem_ack | timed_out);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            last_grant    <= FETCH;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            if_rdata      <= '0;
            d_rdata       <= '0;
            if_valid      <= 1'b0;
            d_valid       <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state         <= GRANT_D;
                        last_grant    <= DATA;
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= d_we;
                        mem.mem_addr  <= d_addr;
                        mem.mem_wdata <= d_wdata;
                    end else if (grant_f) begin
                        state        <= GRANT_F;
                        last_grant   <= FETCH;
                        mem.mem_req  <= 1'b1;
                        mem.mem_we   <= 1'b0;
                        mem.mem_addr <= if_addr;
                    end
                end
                GRANT_F: begin
                    if (done) begin
                        state       <= IDLE;
                        mem.mem_req <= 1'b0;
                        mem.mem_we  <= 1'b0;
                        if_rdata    <= resp_data;
                        if_valid    <= 1'b1;
                    end
                end
                GRANT_D: begin
                    if (done) begin
                        state       <= IDLE;
                        mem.mem_req <= 1'b0;
                        mem.mem_we  <= 1'b0;
                        d_rdata     <= resp_data;
                        d_valid     <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    mem.mem_req <= 1'b0;
                    mem.mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_umem_arbiter.sv
// Directed self-checking bench for umem_arbiter; covers the UMEM_ARB_TIMEOUT_EN build when defined.
module tb_umem_arbiter;

    localparam int XLEN    = 32;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 8;

    logic              clk;
    logic              rstn;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [XLEN-1:0]   if_rdata;
    logic              if_valid;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [XLEN-1:0]   d_wdata;
    logic [XLEN-1:0]   d_rdata;
    logic              d_valid;
    logic              cpu_stall;
    logic              arb_err;

    int checks = 0;
    int errors = 0;

    umem_arbiter_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) mem_bus ();

    umem_arbiter #(
        .XLEN    (XLEN),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .cpu_stall (cpu_stall),
        .mem       (mem_bus.master),
        .arb_err   (arb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic fr, input logic [31:0] fa,
                                 input logic dr, input logic dw,
                                 input logic [31:0] da, input logic [31:0] dd);
        if_req  = fr;
        if_addr = fa;
        d_req   = dr;
        d_we    = dw;
        d_addr  = da;
        d_wdata = dd;
        #1;
    endtask

    task automatic setMem(input logic ack, input logic [31:0] rdata);
        mem_bus.mem_ack   = ack;
        mem_bus.mem_rdata = rdata;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        rstn = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        setMem(0, 0);
        repeat (2) @(posedge clk);
        #1;

        // Everything quiet while held in reset.
        checkOutput("rst_mem_req",   32'(mem_bus.mem_req),   0);
        checkOutput("rst_mem_we",    32'(mem_bus.mem_we),    0);
        checkOutput("rst_mem_addr",  mem_bus.mem_addr,       0);
        checkOutput("rst_mem_wdata", mem_bus.mem_wdata,      0);
        checkOutput("rst_if_valid",  32'(if_valid),          0);
        checkOutput("rst_d_valid",   32'(d_valid),           0);
        checkOutput("rst_if_rdata",  if_rdata,               0);
        checkOutput("rst_d_rdata",   d_rdata,                0);
        checkOutput("rst_arb_err",   32'(arb_err),           0);
        checkOutput("rst_stall",     32'(cpu_stall),         0);
        rstn = 1'b1;
        tick();

        $display("[TB] single fetch");
        applyStimulus(1, 32'h0000_0004, 0, 0, 0, 0);
        checkOutput("f1_stall_on",   32'(cpu_stall),       1);
        checkOutput("f1_req_early",  32'(mem_bus.mem_req), 0);
        tick();
        checkOutput("f1_mem_req",    32'(mem_bus.mem_req), 1);
        checkOutput("f1_mem_addr",   mem_bus.mem_addr,     32'h0000_0004);
        checkOutput("f1_mem_we",     32'(mem_bus.mem_we),  0);
        checkOutput("f1_no_valid",   32'(if_valid),        0);
        setMem(1, 32'h0000_0013);
        tick();
        setMem(0, 0);
        checkOutput("f1_if_valid",   32'(if_valid),        1);
        checkOutput("f1_if_rdata",   if_rdata,             32'h0000_0013);
        checkOutput("f1_req_drop",   32'(mem_bus.mem_req), 0);
        checkOutput("f1_stall_off",  32'(cpu_stall),       0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("f1_valid_pulse", 32'(if_valid),       0);
        checkOutput("f1_idle_req",   32'(mem_bus.mem_req), 0);

        $display("[TB] simultaneous fetch and load");
        applyStimulus(1, 32'h0000_0008, 1, 0, 32'h0000_0100, 0);
        tick();
        checkOutput("s_grant_d_addr", mem_bus.mem_addr,    32'h0000_0100);
        checkOutput("s_grant_d_we",  32'(mem_bus.mem_we),  0);
        setMem(1, 32'hDEAD_BEEF);
        tick();
        setMem(0, 0);
        checkOutput("s_d_valid",     32'(d_valid),         1);
        checkOutput("s_d_rdata",     d_rdata,              32'hDEAD_BEEF);
        checkOutput("s_if_not_valid", 32'(if_valid),       0);
        checkOutput("s_stall_fetch", 32'(cpu_stall),       1);
        // New load issued immediately; fetch is still pending so it must go next.
        applyStimulus(1, 32'h0000_0008, 1, 0, 32'h0000_0104, 0);
        tick();
        checkOutput("s_grant_f_req", 32'(mem_bus.mem_req), 1);
        checkOutput("s_grant_f_addr", mem_bus.mem_addr,    32'h0000_0008);
        checkOutput("s_d_valid_once", 32'(d_valid),        0);
        setMem(1, 32'h0000_0093);
        tick();
        setMem(0, 0);
        checkOutput("s_if_valid",    32'(if_valid),        1);
        checkOutput("s_if_rdata",    if_rdata,             32'h0000_0093);
        applyStimulus(0, 0, 1, 0, 32'h0000_0104, 0);
        tick();
        checkOutput("s_grant_d2_addr", mem_bus.mem_addr,   32'h0000_0104);
        setMem(1, 32'h1111_1111);
        tick();
        setMem(0, 0);
        checkOutput("s_d2_rdata",    d_rdata,              32'h1111_1111);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();

        $display("[TB] fetch wins after a data grant");
        applyStimulus(1, 32'h0000_000C, 1, 0, 32'h0000_0108, 0);
        tick();
        checkOutput("p_fetch_first", mem_bus.mem_addr,     32'h0000_000C);
        setMem(1, 32'h0000_0033);
        tick();
        setMem(0, 0);
        checkOutput("p_if_valid",    32'(if_valid),        1);
        checkOutput("p_d_waiting",   32'(d_valid),         0);
        applyStimulus(0, 0, 1, 0, 32'h0000_0108, 0);
        tick();
        checkOutput("p_data_next",   mem_bus.mem_addr,     32'h0000_0108);
        setMem(1, 32'h0000_0044);
        tick();
        setMem(0, 0);
        checkOutput("p_d_rdata",     d_rdata,              32'h0000_0044);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();

        $display("[TB] store with 3-cycle ack");
        applyStimulus(0, 0, 1, 1, 32'h0000_0200, 32'h1234_5678);
        tick();
        for (int i = 0; i < 3; i++) begin
            checkOutput("st_mem_req",   32'(mem_bus.mem_req), 1);
            checkOutput("st_mem_we",    32'(mem_bus.mem_we),  1);
            checkOutput("st_mem_addr",  mem_bus.mem_addr,     32'h0000_0200);
            checkOutput("st_mem_wdata", mem_bus.mem_wdata,    32'h1234_5678);
            checkOutput("st_no_valid",  32'(d_valid),         0);
            if (i == 2) setMem(1, 32'hA5A5_A5A5);
            tick();
        end
        setMem(0, 0);
        checkOutput("st_d_valid",    32'(d_valid),         1);
        checkOutput("st_we_low",     32'(mem_bus.mem_we),  0);
        checkOutput("st_req_low",    32'(mem_bus.mem_req), 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("st_valid_once", 32'(d_valid),         0);
        checkOutput("st_we_after",   32'(mem_bus.mem_we),  0);

        $display("[TB] spurious ack while idle");
        setMem(1, 32'hFFFF_FFFF);
        tick();
        tick();
        checkOutput("sp_if_valid",   32'(if_valid),        0);
        checkOutput("sp_d_valid",    32'(d_valid),         0);
        checkOutput("sp_mem_req",    32'(mem_bus.mem_req), 0);
        checkOutput("sp_d_rdata",    d_rdata,              32'hA5A5_A5A5);
        checkOutput("sp_if_rdata",   if_rdata,             32'h0000_0033);
        setMem(0, 0);
        tick();

        $display("[TB] reset during transaction");
        applyStimulus(0, 0, 1, 1, 32'h0000_0300, 32'h0BAD_F00D);
        tick();
        checkOutput("r_mem_req_on",  32'(mem_bus.mem_req), 1);
        rstn = 1'b0;
        #1;
        checkOutput("r_mem_req_off", 32'(mem_bus.mem_req), 0);
        checkOutput("r_mem_we_off",  32'(mem_bus.mem_we),  0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        setMem(1, 32'h5555_5555);
        tick();
        setMem(0, 0);
        checkOutput("r_no_d_valid",  32'(d_valid),         0);
        rstn = 1'b1;
        tick();
        checkOutput("r_idle_req",    32'(mem_bus.mem_req), 0);
        checkOutput("r_idle_valid",  32'(d_valid),         0);
        applyStimulus(1, 32'h0000_0050, 0, 0, 0, 0);
        tick();
        checkOutput("r_regrant_addr", mem_bus.mem_addr,    32'h0000_0050);

`ifdef UMEM_ARB_TIMEOUT_EN
        $display("[TB] watchdog timeout");
        for (int i = 0; i < TIMEOUT; i++) begin
            checkOutput("to_req_held", 32'(mem_bus.mem_req), 1);
            checkOutput("to_err_clear", 32'(arb_err),        0);
            tick();
        end
        checkOutput("to_req_drop",   32'(mem_bus.mem_req), 0);
        checkOutput("to_if_valid",   32'(if_valid),        1);
        checkOutput("to_if_rdata",   if_rdata,             0);
        checkOutput("to_arb_err",    32'(arb_err),         1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("to_err_sticky", 32'(arb_err),         1);
        applyStimulus(1, 32'h0000_0060, 0, 0, 0, 0);
        tick();
        setMem(1, 32'h0000_0077);
        tick();
        setMem(0, 0);
        checkOutput("to_ok_rdata",   if_rdata,             32'h0000_0077);
        checkOutput("to_err_still",  32'(arb_err),         1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        rstn = 1'b0;
        #1;
        checkOutput("to_err_reset",  32'(arb_err),         0);
        rstn = 1'b1;
        tick();
`else
        $display("[TB] grant waits without watchdog");
        repeat (12) tick();
        checkOutput("nw_req_held",   32'(mem_bus.mem_req), 1);
        checkOutput("nw_no_valid",   32'(if_valid),        0);
        checkOutput("nw_arb_err",    32'(arb_err),         0);
        setMem(1, 32'h0000_0077);
        tick();
        setMem(0, 0);
        checkOutput("nw_if_rdata",   if_rdata,             32'h0000_0077);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
